rv32i_dmem_responder: RTL and testbench
=======================================

Name: rv32i_dmem_responder

Overview:
- Responder (slave) side of the core's data-memory strobe/ack interface.
- Accepts a single-cycle load/store strobe and latches address, store data and byte mask.
- Asserts a one-cycle ack after a fixed, parameterised latency. Returns a full 32-bit word on reads and commits byte-masked writes.
- Sits between the pipeline's memory-access stage and the on-chip data RAM. Also flags out-of-range accesses.

Parameters:
- MEMORY_DEPTH, 1024, number of 32-bit words; power of two, at least 2.
- ACK_LATENCY, 1, cycles from the accepted strobe to ack; legal range 1..15.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  asynchronous active-high reset
- i_stb_data  in  1  request pulse from the initiator; one cycle per transaction
- i_wr_mem  in  1  1 = store, 0 = load; sampled with i_stb_data
- i_wr_mask  in  4  byte-lane enables {b3,b2,b1,b0}; sampled with i_stb_data; ignored for loads
- i_addr  in  32  byte address; word index = i_addr[AW+1:2], where AW = clog2(MEMORY_DEPTH)
- i_data_store  in  32  lane-aligned store data
- o_din  out  32  read data; valid in the ack cycle
- o_ack_data  out  1  one-cycle completion pulse
- o_busy  out  1  a transaction is in flight (WAIT state)
- o_err  out  1  out-of-range flag; pulses together with o_ack_data

Behaviour:
- Reset: o_ack_data = 0, o_din = 0, o_err = 0, o_busy = 0; state = IDLE; latency counter = 0. The RAM contents are not reset.
- States: IDLE, WAIT, ACK.
- IDLE + i_stb_data:
  - Latch word index, we, mask, store data and the range check.
  - Range check: any of i_addr[31:AW+2] set.
  - Load counter with ACK_LATENCY-1.
  - Next state: ACK if ACK_LATENCY == 1, else WAIT.
- WAIT:
  - o_busy = 1; counter decrements each cycle.
  - When the counter reaches 1, go to ACK.
- ACK:
  - o_ack_data = 1 for exactly this cycle; o_err = the latched range flag.
  - i_stb_data in this cycle is accepted as a new transaction, same rules as IDLE. This allows back-to-back requests.
  - Otherwise return to IDLE.
- Timing: a strobe sampled at edge t gives o_ack_data high in the cycle after edge t+ACK_LATENCY-1. With the default latency, ack appears in the cycle immediately following the strobe cycle.
- Store commit:
  - RAM write happens on the edge that enters ACK.
  - Only lanes with mask=1 are written; lane k = bits [8k+7:8k].
  - Mask 0000 writes nothing but still acks.
  - Out-of-range store: no write; ack + err.
- Load:
  - o_din = whole word at the latched index, registered, valid in the ack cycle.
  - o_din holds its value until the next load ack.
  - Store acks do not change o_din.
  - Out-of-range load: o_din = 0, err = 1.
- i_stb_data while in WAIT: ignored (dropped, no ack); o_busy signals this to the initiator.
- Simultaneous events:
  - Read-after-write to the same word with back-to-back strobes: the load returns the newly written bytes.
  - The store commits at ACK entry, before the load's RAM read in the following cycle.
- Reset mid-operation:
  - The in-flight transaction is abandoned: no ack and no write unless ACK was already entered.
  - The RAM keeps its contents.
- Address bits [1:0] are ignored; lane selection comes from the mask.
- The i_wr_mem/i_wr_mask/i_addr/i_data_store values outside the strobe cycle do not matter.

Decomposition:
- rv32i_header.vh gains:
  - DMEM_LANES = 4
  - DMEM_MAX_LATENCY = 15
  - Localparams for the state encoding: IDLE = 2'd0, WAIT = 2'd1, ACK = 2'd2.
- Sub-module rv32i_dmem_bram:
  - Single-port, byte-enable, registered-read RAM with parameter DEPTH.
  - Ports: clk, en, we, be[3:0], addr, wdata, rdata.
  - Inferable as block RAM.
- The responder owns the FSM, latency counter and range check.

Test Plan:
- Default latency; store 0xDEADBEEF, mask 1111, addr 0x10 at cycle 0 -> ack in cycle 1, err 0; then load addr 0x10 -> o_din = 0xDEADBEEF in its ack cycle.
- Prior word 0x11223344 at 0x20; store 0x0000AB00, mask 0010 -> subsequent load returns 0x1122AB44; mask 0000 store -> ack, word unchanged.
- ACK_LATENCY = 4:
  - Strobe at cycle 0 -> o_busy high in cycles 1-3, ack in cycle 4 only.
  - Second strobe in cycle 2 is dropped (no extra ack).
  - Strobe in cycle 4 is accepted -> ack in cycle 8.
- Back-to-back: store 0x55 to 0x40 (mask 0001), then load 0x40 strobed in that store's ack cycle -> load ack returns low byte 0x55.
- Out-of-range (MEMORY_DEPTH = 1024): load 0x00001000 -> ack + o_err = 1, o_din = 0; store 0x00001000 -> ack + err, word 0 unchanged.
- Reset asserted in WAIT with ACK_LATENCY = 4 (store pending) -> no ack; outputs 0 while in reset; after release, a load of that address returns the old data.

Source files
------------

// File: rtl/rv32i_dmem_responder_pkg.sv
// Shared constants and FSM state encoding for the data-memory responder.
package rv32i_dmem_responder_pkg;
  localparam int DMEM_LANES       = 4;
  localparam int DMEM_MAX_LATENCY = 15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } dmem_state_e;
endpackage

// File: rtl/rv32i_dmem_bram.sv
// Single-port byte-enable RAM with registered read; written in a block-RAM inferable form.
module rv32i_dmem_bram
  import rv32i_dmem_responder_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [DMEM_LANES-1:0] be,
  input  logic [AW-1:0]         addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);
  logic [31:0] mem_q [DEPTH];

  // Read-first: a store cycle returns the old word, which the responder never uses.
  always_ff @(posedge clk) begin
    if (en) begin
      for (int k = 0; k < DMEM_LANES; k++) begin
        if (we && be[k]) mem_q[addr][8*k +: 8] <= wdata[8*k +: 8];
      end
      rdata <= mem_q[addr];
    end
  end
endmodule

// File: rtl/rv32i_dmem_responder.sv
// Strobe/ack data-memory responder: latches a request, acks after ACK_LATENCY cycles,
// commits byte-masked stores and returns registered load data; flags out-of-range accesses.
module rv32i_dmem_responder
  import rv32i_dmem_responder_pkg::*;
#(
  parameter int MEMORY_DEPTH = 1024,
  parameter int ACK_LATENCY  = 1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_stb_data,
  input  logic        i_wr_mem,
  input  logic [3:0]  i_wr_mask,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_data_store,
  output logic [31:0] o_din,
  output logic        o_ack_data,
  output logic        o_busy,
  output logic        o_err
);
  localparam int         AW       = $clog2(MEMORY_DEPTH);
  localparam logic [3:0] CNT_LOAD = 4'(ACK_LATENCY - 1);

  dmem_state_e     state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [AW-1:0]   idx_q;
  logic            we_q;
  logic [3:0]      mask_q;
  logic [31:0]     data_q;
  logic            err_q;
  logic [31:0]     din_q;

  logic            accept, enter_ack, oor_in;
  logic [AW-1:0]   idx_in, ram_addr;
  logic            ram_we;
  logic [3:0]      ram_be;
  logic [31:0]     ram_wdata, ram_rdata, load_val;
  logic            unused_addr_bits;

  assign idx_in           = i_addr[AW+1:2];
  assign unused_addr_bits = ^i_addr[1:0];

  generate
    if (AW + 2 < 32) begin : g_range
      assign oor_in = |i_addr[31:AW+2];
    end else begin : g_full
      assign oor_in = 1'b0;
    end
  endgenerate

  assign accept = i_stb_data && (state_q != WAIT);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    o_busy     = 1'b0;
    o_ack_data = 1'b0;
    unique case (state_q)
      IDLE, ACK: begin
        o_ack_data = (state_q == ACK);
        if (i_stb_data) begin
          cnt_d   = CNT_LOAD;
          state_d = (ACK_LATENCY == 1) ? ACK : WAIT;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        o_busy = 1'b1;
        if (cnt_q == 4'd1) begin
          state_d = ACK;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // With latency 1 the RAM access happens on the accepting edge, so it must see the live request.
  assign enter_ack = (state_d == ACK);
  assign ram_addr  = accept ? idx_in : idx_q;
  assign ram_we    = accept ? (i_wr_mem & ~oor_in) : (we_q & ~err_q);
  assign ram_be    = accept ? i_wr_mask : mask_q;
  assign ram_wdata = accept ? i_data_store : data_q;

  rv32i_dmem_bram #(.DEPTH(MEMORY_DEPTH), .AW(AW)) u_bram (
    .clk   (i_clk),
    .en    (enter_ack),
    .we    (ram_we),
    .be    (ram_be),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  assign load_val = err_q ? 32'd0 : ram_rdata;
  assign o_din    = (state_q == ACK && !we_q) ? load_val : din_q;
  assign o_err    = (state_q == ACK) && err_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      we_q    <= 1'b0;
      mask_q  <= 4'd0;
      data_q  <= 32'd0;
      err_q   <= 1'b0;
      din_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        idx_q  <= idx_in;
        we_q   <= i_wr_mem;
        mask_q <= i_wr_mask;
        data_q <= i_data_store;
        err_q  <= oor_in;
      end
      if (state_q == ACK && !we_q) din_q <= load_val;
    end
  end
endmodule

// File: tb/tb_rv32i_dmem_responder.sv
// Randomised and directed bench for rv32i_dmem_responder at latencies 1 and 4.
module tb_rv32i_dmem_responder;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stb1 = 1'b0, stb4 = 1'b0, wr = 1'b0;
  logic [3:0]  mask = 4'd0;
  logic [31:0] addr = 32'd0, wdata = 32'd0;
  logic [31:0] din1, din4;
  logic        ack1, ack4, busy1, busy4, err1, err4;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [31:0] mem1 [1024];
  logic [31:0] mem4 [1024];
  logic [31:0] last1 = 32'd0, last4 = 32'd0;

  always #5 clk = ~clk;

  rv32i_dmem_responder #(.MEMORY_DEPTH(1024), .ACK_LATENCY(1)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_stb_data(stb1), .i_wr_mem(wr), .i_wr_mask(mask),
    .i_addr(addr), .i_data_store(wdata), .o_din(din1), .o_ack_data(ack1),
    .o_busy(busy1), .o_err(err1));

  rv32i_dmem_responder #(.MEMORY_DEPTH(1024), .ACK_LATENCY(4)) dut4 (
    .i_clk(clk), .i_rst(rst), .i_stb_data(stb4), .i_wr_mem(wr), .i_wr_mask(mask),
    .i_addr(addr), .i_data_store(wdata), .o_din(din4), .o_ack_data(ack4),
    .o_busy(busy4), .o_err(err4));

  task automatic drive(input logic w, input logic [3:0] m, input logic [31:0] a, input logic [31:0] d);
    wr = w; mask = m; addr = a; wdata = d;
  endtask

  task automatic drive_junk();
    drive(1'($urandom % 2), 4'($urandom), $urandom, $urandom);
  endtask

  task automatic sample(input int lat, output logic ack, output logic busy, output logic err,
                        output logic [31:0] din);
    if (lat == 1) begin ack = ack1; busy = busy1; err = err1; din = din1; end
    else begin ack = ack4; busy = busy4; err = err4; din = din4; end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [3:0] m, input logic [31:0] d);
    logic [31:0] r;
    r = old;
    for (int k = 0; k < 4; k++) if (m[k]) r[8*k +: 8] = d[8*k +: 8];
    return r;
  endfunction

  // Memory is 1024 words = 4 KiB; anything at or above 0x1000 is out of range.
  task automatic model_txn(input int lat, input logic w, input logic [3:0] m, input logic [31:0] a,
                           input logic [31:0] d, output logic [31:0] exp_din, output logic exp_err);
    int idx;
    idx = int'(a[11:2]);
    exp_err = (a >= 32'h1000);
    if (lat == 1) begin
      if (w) begin
        if (!exp_err) mem1[idx] = merge(mem1[idx], m, d);
        exp_din = last1;
      end else begin
        exp_din = exp_err ? 32'd0 : mem1[idx];
        last1 = exp_din;
      end
    end else begin
      if (w) begin
        if (!exp_err) mem4[idx] = merge(mem4[idx], m, d);
        exp_din = last4;
      end else begin
        exp_din = exp_err ? 32'd0 : mem4[idx];
        last4 = exp_din;
      end
    end
  endtask

  // Entered and left just after a rising edge with the selected DUT idle.
  task automatic run_txn(input int lat, input logic w, input logic [3:0] m, input logic [31:0] a,
                         input logic [31:0] d, input string tag);
    logic [31:0] exp_din, din;
    logic exp_err, ack, busy, err, e_ack, e_busy, e_err;
    model_txn(lat, w, m, a, d, exp_din, exp_err);
    drive(w, m, a, d);
    if (lat == 1) stb1 = 1'b1; else stb4 = 1'b1;
    @(posedge clk); #1;
    stb1 = 1'b0; stb4 = 1'b0;
    drive_junk();
    for (int c = 1; c <= lat + 1; c++) begin
      @(negedge clk);
      sample(lat, ack, busy, err, din);
      e_ack = (c == lat); e_busy = (c < lat); e_err = (c == lat) && exp_err;
      n_cmp++; if (ack !== e_ack) begin n_fail++; $display("FAIL %s ack c=%0d: got %b want %b", tag, c, ack, e_ack); end
      n_cmp++; if (busy !== e_busy) begin n_fail++; $display("FAIL %s busy c=%0d: got %b want %b", tag, c, busy, e_busy); end
      n_cmp++; if (err !== e_err) begin n_fail++; $display("FAIL %s err c=%0d: got %b want %b", tag, c, err, e_err); end
      if (c >= lat) begin
        n_cmp++; if (din !== exp_din) begin n_fail++; $display("FAIL %s din c=%0d: got %h want %h", tag, c, din, exp_din); end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++; if ({ack1, busy1, err1} !== 3'b000) begin n_fail++; $display("FAIL reset ctl1: got %b want 000", {ack1, busy1, err1}); end
    n_cmp++; if ({ack4, busy4, err4} !== 3'b000) begin n_fail++; $display("FAIL reset ctl4: got %b want 000", {ack4, busy4, err4}); end
    n_cmp++; if (din1 !== 32'd0) begin n_fail++; $display("FAIL reset din1: got %h want 0", din1); end
    n_cmp++; if (din4 !== 32'd0) begin n_fail++; $display("FAIL reset din4: got %h want 0", din4); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_init();
    for (int i = 0; i < 16; i++) begin
      run_txn(1, 1'b1, 4'hF, 32'(i * 4), $urandom, "init1");
      run_txn(4, 1'b1, 4'hF, 32'(i * 4), $urandom, "init4");
    end
  endtask

  task automatic test_basic();
    run_txn(1, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF, "basic_st");
    run_txn(1, 1'b0, 4'hF, 32'h10, 32'h0, "basic_ld");
    n_cmp++; if (last1 !== 32'hDEADBEEF) begin n_fail++; $display("FAIL basic_word: got %h want deadbeef", last1); end
  endtask

  task automatic test_mask();
    run_txn(1, 1'b1, 4'hF, 32'h20, 32'h11223344, "mask_init");
    run_txn(1, 1'b1, 4'b0010, 32'h21, 32'h0000AB00, "mask_st");
    run_txn(1, 1'b0, 4'h0, 32'h20, 32'h0, "mask_ld");
    n_cmp++; if (din1 !== 32'h1122AB44) begin n_fail++; $display("FAIL mask_word: got %h want 1122ab44", din1); end
    run_txn(1, 1'b1, 4'b0000, 32'h20, 32'hFFFFFFFF, "mask0_st");
    run_txn(1, 1'b0, 4'hF, 32'h20, 32'h0, "mask0_ld");
    n_cmp++; if (din1 !== 32'h1122AB44) begin n_fail++; $display("FAIL mask0_word: got %h want 1122ab44", din1); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_s, exp_l;
    logic er;
    run_txn(1, 1'b1, 4'hF, 32'h40, 32'hCAFEF00D, "b2b_init");
    model_txn(1, 1'b1, 4'b0001, 32'h40, 32'h00000055, exp_s, er);
    model_txn(1, 1'b0, 4'hF, 32'h40, 32'h0, exp_l, er);
    drive(1'b1, 4'b0001, 32'h40, 32'h00000055); stb1 = 1'b1;
    @(posedge clk); #1;
    drive(1'b0, 4'hF, 32'h42, $urandom);
    @(negedge clk);
    n_cmp++; if ({ack1, err1} !== 2'b10) begin n_fail++; $display("FAIL b2b_st_ack: got %b want 10", {ack1, err1}); end
    n_cmp++; if (din1 !== exp_s) begin n_fail++; $display("FAIL b2b_st_din: got %h want %h", din1, exp_s); end
    @(posedge clk); #1;
    stb1 = 1'b0; drive_junk();
    @(negedge clk);
    n_cmp++; if ({ack1, err1} !== 2'b10) begin n_fail++; $display("FAIL b2b_ld_ack: got %b want 10", {ack1, err1}); end
    n_cmp++; if (din1 !== exp_l) begin n_fail++; $display("FAIL b2b_ld_din: got %h want %h", din1, exp_l); end
    n_cmp++; if (din1[7:0] !== 8'h55) begin n_fail++; $display("FAIL b2b_lowbyte: got %h want 55", din1[7:0]); end
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++; if (ack1 !== 1'b0) begin n_fail++; $display("FAIL b2b_tail_ack: got %b want 0", ack1); end
    @(posedge clk); #1;
  endtask

  task automatic test_out_of_range();
    run_txn(1, 1'b0, 4'hF, 32'h00001000, 32'h0, "oor_ld");
    run_txn(1, 1'b1, 4'hF, 32'h00001000, 32'h12345678, "oor_st");
    run_txn(1, 1'b0, 4'hF, 32'h00000000, 32'h0, "oor_word0");
    run_txn(1, 1'b0, 4'hF, 32'h80000004, 32'h0, "oor_high");
  endtask

  task automatic test_latency4();
    run_txn(4, 1'b1, 4'hF, 32'h30, 32'hA5A5_0F0F, "lat4_st");
    run_txn(4, 1'b1, 4'hF, 32'h34, 32'h01020304, "lat4_st2");
    run_txn(4, 1'b0, 4'hF, 32'h30, 32'h0, "lat4_ld");
  endtask

  task automatic test_drop_in_wait();
    logic [31:0] ea, eb;
    logic er, e_ack, e_busy;
    model_txn(4, 1'b0, 4'hF, 32'h30, 32'h0, ea, er);
    model_txn(4, 1'b0, 4'hF, 32'h34, 32'h0, eb, er);
    drive(1'b0, 4'hF, 32'h30, 32'h0); stb4 = 1'b1;
    @(posedge clk); #1;
    for (int c = 1; c <= 9; c++) begin
      if (c == 2) begin drive(1'b1, 4'hF, 32'h34, 32'hFFFFFFFF); stb4 = 1'b1; end
      else if (c == 4) begin drive(1'b0, 4'hF, 32'h34, 32'h0); stb4 = 1'b1; end
      else begin stb4 = 1'b0; drive_junk(); end
      @(negedge clk);
      e_ack  = (c == 4) || (c == 8);
      e_busy = (c >= 1 && c <= 3) || (c >= 5 && c <= 7);
      n_cmp++; if (ack4 !== e_ack) begin n_fail++; $display("FAIL drop ack c=%0d: got %b want %b", c, ack4, e_ack); end
      n_cmp++; if (busy4 !== e_busy) begin n_fail++; $display("FAIL drop busy c=%0d: got %b want %b", c, busy4, e_busy); end
      n_cmp++; if (err4 !== 1'b0) begin n_fail++; $display("FAIL drop err c=%0d: got %b want 0", c, err4); end
      if (c == 4) begin
        n_cmp++; if (din4 !== ea) begin n_fail++; $display("FAIL drop din_a: got %h want %h", din4, ea); end
      end
      if (c == 8) begin
        n_cmp++; if (din4 !== eb) begin n_fail++; $display("FAIL drop din_b: got %h want %h", din4, eb); end
      end
      @(posedge clk); #1;
    end
    stb4 = 1'b0;
  endtask

  task automatic test_reset_mid();
    run_txn(4, 1'b1, 4'hF, 32'h50, 32'h600DF00D, "rmid_init");
    drive(1'b1, 4'hF, 32'h50, 32'hBAADBAAD); stb4 = 1'b1;
    @(posedge clk); #1;
    stb4 = 1'b0; drive_junk();
    @(negedge clk);
    n_cmp++; if (busy4 !== 1'b1) begin n_fail++; $display("FAIL rmid_busy: got %b want 1", busy4); end
    @(posedge clk); #1;
    rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_cmp++; if ({ack4, busy4, err4} !== 3'b000) begin n_fail++; $display("FAIL rmid_ctl c=%0d: got %b want 000", c, {ack4, busy4, err4}); end
      n_cmp++; if (din4 !== 32'd0) begin n_fail++; $display("FAIL rmid_din c=%0d: got %h want 0", c, din4); end
      @(posedge clk); #1;
    end
    rst = 1'b0;
    last1 = 32'd0; last4 = 32'd0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_cmp++; if ({ack1, ack4} !== 2'b00) begin n_fail++; $display("FAIL rmid_noack c=%0d: got %b want 00", c, {ack1, ack4}); end
      @(posedge clk); #1;
    end
    run_txn(4, 1'b0, 4'hF, 32'h50, 32'h0, "rmid_ld");
  endtask

  task automatic test_random();
    int lat;
    logic w;
    logic [31:0] a;
    for (int i = 0; i < 80; i++) begin
      lat = ($urandom % 2 == 0) ? 1 : 4;
      w = 1'($urandom % 2);
      a = 32'(($urandom % 16) * 4 + ($urandom % 4));
      if ($urandom % 8 == 0) a = a | (32'($urandom_range(1, 32'hFFFFF)) << 12);
      run_txn(lat, w, 4'($urandom), a, $urandom, "rand");
    end
  endtask

  initial begin
    test_reset();
    test_init();
    test_basic();
    test_mask();
    test_back_to_back();
    test_out_of_range();
    test_latency4();
    test_drop_in_wait();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
